// File: rtl/decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_ctrl_stage
// Brief    : Registered RV32IM control decoder with valid/ready handshake,
//            multi-cycle MUL/DIV occupancy, illegal-op flagging and flush.
// Revision : 1.0 - initial release
// ============================================================================
module decode_ctrl_stage #(
    parameter int unsigned MUL_LATENCY = 1,
    parameter int unsigned DIV_LATENCY = 4,
    parameter bit          ENABLE_M    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  alu_signal,
    output logic        reg_file_write,
    output logic [2:0]  main_mem_write,
    output logic [3:0]  main_mem_read,
    output logic [3:0]  branch_control,
    output logic [3:0]  immediate_select,
    output logic        operand_1_select,
    output logic        operand_2_select,
    output logic [1:0]  reg_write_select,
    output logic        illegal
);

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_busy  = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    localparam int unsigned c_max_lat = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int unsigned c_cnt_w   = $clog2(c_max_lat + 1);
    localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MUL_LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_div_load = c_cnt_w'(DIV_LATENCY - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam int unsigned c_bw = 27;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused_fields;

    assign w_opcode        = instruction[6:0];
    assign w_funct3        = instruction[14:12];
    assign w_funct7        = instruction[31:25];
    assign w_unused_fields = ^{instruction[24:15], instruction[11:7]};

    logic w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store, w_opimm, w_op;
    logic w_mext, w_alt, w_known, w_illegal, w_jump;

    assign w_lui    = (w_opcode == c_opc_lui);
    assign w_auipc  = (w_opcode == c_opc_auipc);
    assign w_jal    = (w_opcode == c_opc_jal);
    assign w_jalr   = (w_opcode == c_opc_jalr);
    assign w_branch = (w_opcode == c_opc_branch);
    assign w_load   = (w_opcode == c_opc_load);
    assign w_store  = (w_opcode == c_opc_store);
    assign w_opimm  = (w_opcode == c_opc_opimm);
    assign w_op     = (w_opcode == c_opc_op);
    assign w_mext   = w_op && (w_funct7 == 7'b0000001);
    assign w_alt    = (w_funct7 == 7'b0100000);
    assign w_jump   = w_jal || w_jalr;
    assign w_known  = w_lui || w_auipc || w_jump || w_branch || w_load
                   || w_store || w_opimm || w_op;
    assign w_illegal = !w_known || (w_mext && !ENABLE_M);

    logic [5:0] w_alu;
    logic [3:0] w_imm;
    logic       w_imm_unsigned;

    always_comb begin
        w_alu = 6'b000000;
        w_alu[2:0] = (w_auipc || w_jal || w_load || w_store || w_branch) ? 3'b000 : w_funct3;
        w_alu[3]   = w_mext || w_lui;
        w_alu[4]   = (w_op && w_alt && (w_funct3 == 3'b000))
                  || (w_op && w_alt && (w_funct3 == 3'b101))
                  || (w_opimm && w_alt && (w_funct3 == 3'b101))
                  || w_lui;
    end

    assign w_imm_unsigned = (w_load && ((w_funct3 == 3'b100) || (w_funct3 == 3'b101)))
                         || (w_opimm && (w_funct3 == 3'b011))
                         || (w_op && (w_funct7 == 7'b0000000) && (w_funct3 == 3'b011))
                         || (w_mext && ((w_funct3 == 3'b010) || (w_funct3 == 3'b011)
                                        || (w_funct3 == 3'b111)));

    always_comb begin
        w_imm = 4'b0000;
        if (w_opimm && (w_funct3[1:0] == 2'b01)) begin
            w_imm[2:0] = 3'b101;
        end else if (w_load || w_jalr || w_opimm) begin
            w_imm[2:0] = 3'b010;
        end else if (w_jal) begin
            w_imm[2:0] = 3'b001;
        end else if (w_branch) begin
            w_imm[2:0] = 3'b011;
        end else if (w_store) begin
            w_imm[2:0] = 3'b100;
        end else begin
            w_imm[2:0] = 3'b000;
        end
        w_imm[3] = w_imm_unsigned;
    end

    logic [c_bw-1:0] w_bundle;

    // Illegal ops are neutralised here so execute never sees a side effect.
    assign w_bundle = {
        w_alu,
        !(w_store || w_branch || w_illegal),
        w_store && !w_illegal, w_funct3[1:0],
        w_load && !w_illegal, w_funct3,
        (w_jump || w_branch) && !w_illegal, (w_jump ? 3'b010 : w_funct3),
        w_imm,
        w_auipc || w_jump,
        !w_op,
        w_auipc || w_jump, !w_load,
        w_illegal
    };

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_next_cnt;
    logic [c_cnt_w-1:0]  w_lat_load;
    logic [c_bw-1:0]     r_bundle;
    logic                w_accept;
    logic                w_needs_busy;

    assign w_accept     = in_valid && in_ready && !flush;
    assign w_lat_load   = w_funct3[2] ? c_div_load : c_mul_load;
    assign w_needs_busy = w_mext && !w_illegal && (w_lat_load != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_empty;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (flush) begin
            w_next_state = c_st_empty;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                c_st_empty, c_st_full: begin
                    if (w_accept) begin
                        if (w_needs_busy) begin
                            w_next_state = c_st_busy;
                            w_next_cnt   = w_lat_load;
                        end else begin
                            w_next_state = c_st_full;
                            w_next_cnt   = '0;
                        end
                    end else if ((r_state == c_st_full) && out_ready) begin
                        w_next_state = c_st_empty;
                    end
                end
                c_st_busy: begin
                    if (r_cnt <= c_cnt_one) begin
                        w_next_state = c_st_full;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    w_next_state = c_st_empty;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_st_empty: in_ready = 1'b1;
            c_st_full: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // The bundle register only moves on an accepted, non-flushed transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bundle <= '0;
        end else if (w_accept) begin
            r_bundle <= w_bundle;
        end
    end

    assign {alu_signal, reg_file_write, main_mem_write, main_mem_read, branch_control,
            immediate_select, operand_1_select, operand_2_select, reg_write_select,
            illegal} = r_bundle;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_ctrl_stage
// Brief    : Directed scoreboard bench for decode_ctrl_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_valid_b, out_ready, flush;
    logic [31:0] instruction;

    logic        in_ready, out_valid, reg_file_write, operand_1_select, operand_2_select, illegal;
    logic [5:0]  alu_signal;
    logic [2:0]  main_mem_write;
    logic [3:0]  main_mem_read, branch_control, immediate_select;
    logic [1:0]  reg_write_select;

    logic        b_in_ready, b_out_valid, b_reg_file_write, b_op1, b_op2, b_illegal;
    logic [5:0]  b_alu_signal;
    logic [2:0]  b_main_mem_write;
    logic [3:0]  b_main_mem_read, b_branch_control, b_immediate_select;
    logic [1:0]  b_reg_write_select;

    logic [26:0] bundle_a;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.MUL_LATENCY(1), .DIV_LATENCY(4), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_signal(alu_signal), .reg_file_write(reg_file_write),
        .main_mem_write(main_mem_write), .main_mem_read(main_mem_read),
        .branch_control(branch_control), .immediate_select(immediate_select),
        .operand_1_select(operand_1_select), .operand_2_select(operand_2_select),
        .reg_write_select(reg_write_select), .illegal(illegal)
    );

    // Second instance: M disabled and a multi-cycle MUL, so a wrongly legal MUL would stall.
    decode_ctrl_stage #(.MUL_LATENCY(3), .DIV_LATENCY(4), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .in_valid(in_valid_b),
        .in_ready(b_in_ready), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .alu_signal(b_alu_signal), .reg_file_write(b_reg_file_write),
        .main_mem_write(b_main_mem_write), .main_mem_read(b_main_mem_read),
        .branch_control(b_branch_control), .immediate_select(b_immediate_select),
        .operand_1_select(b_op1), .operand_2_select(b_op2),
        .reg_write_select(b_reg_write_select), .illegal(b_illegal)
    );

    assign bundle_a = {alu_signal, reg_file_write, main_mem_write, main_mem_read, branch_control,
                       immediate_select, operand_1_select, operand_2_select, reg_write_select,
                       illegal};

    int checks = 0;
    int errors = 0;

    logic [26:0] sb_exp[$];
    logic [26:0] sb_mask[$];
    string       sb_tag[$];

    function automatic logic [26:0] mk(input logic [5:0] alu, input logic rfw,
                                       input logic [2:0] mmw, input logic [3:0] mmr,
                                       input logic [3:0] bc, input logic [3:0] imm,
                                       input logic o1, input logic o2,
                                       input logic [1:0] rws, input logic ill);
        return {alu, rfw, mmw, mmr, bc, imm, o1, o2, rws, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [26:0] e, input logic [26:0] m);
        sb_exp.push_back(e);
        sb_mask.push_back(m);
        sb_tag.push_back(tag);
    endtask

    task automatic pop_check();
        logic [26:0] e, m;
        string       t;
        if (sb_exp.size() == 0) begin
            check("unexpected_output", 32'(bundle_a), 32'h0bad_0000);
        end else begin
            e = sb_exp.pop_front();
            m = sb_mask.pop_front();
            t = sb_tag.pop_front();
            check(t, 32'(bundle_a & m), 32'(e & m));
        end
    endtask

    // One clock; a bundle that appears fresh after the edge is scored.
    task automatic step();
        logic was_valid, consumed;
        was_valid = out_valid;
        consumed  = out_valid && out_ready;
        @(posedge clk);
        #1;
        if (out_valid && (!was_valid || consumed)) pop_check();
    endtask

    localparam logic [31:0] c_add   = 32'h0020_8033;
    localparam logic [31:0] c_sub   = 32'h4020_8033;
    localparam logic [31:0] c_sw    = 32'h0020_A023;
    localparam logic [31:0] c_sltiu = 32'h0050_B093;
    localparam logic [31:0] c_addi  = 32'h0050_0093;
    localparam logic [31:0] c_div   = 32'h0220_C033;
    localparam logic [31:0] c_mul   = 32'h0220_8033;
    localparam logic [31:0] c_bad   = 32'h0000_007F;
    localparam logic [31:0] c_lui   = 32'h1234_00B7;
    localparam logic [31:0] c_jal   = 32'h0080_00EF;
    localparam logic [31:0] c_beq   = 32'h0020_8463;

    logic [26:0] all_m, e_add, e_sw, e_sltiu, e_div, e_mul, e_ill, m_ill;
    logic [31:0] s_instr[4];
    logic [26:0] s_exp[4];
    string       s_tag[4];

    initial begin
        all_m   = '1;
        e_add   = mk(6'b000000, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b01, 1'b0);
        e_sw    = mk(6'b000000, 1'b0, 3'b110, 4'b0010, 4'b0010, 4'b0100, 1'b0, 1'b1, 2'b01, 1'b0);
        e_sltiu = mk(6'b000011, 1'b1, 3'b011, 4'b0011, 4'b0011, 4'b1010, 1'b0, 1'b1, 2'b01, 1'b0);
        e_div   = mk(6'b001100, 1'b1, 3'b000, 4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'b01, 1'b0);
        e_mul   = mk(6'b001000, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b01, 1'b0);
        e_ill   = mk(6'b000000, 1'b0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1);
        m_ill   = mk(6'b000000, 1'b1, 3'b100, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1);
        s_instr = '{c_lui, c_jal, c_beq, c_sub};
        s_tag   = '{"lui", "jal", "beq", "sub"};
        s_exp[0] = mk(6'b011000, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'b01, 1'b0);
        s_exp[1] = mk(6'b000000, 1'b1, 3'b000, 4'b0000, 4'b1010, 4'b0001, 1'b1, 1'b1, 2'b11, 1'b0);
        s_exp[2] = mk(6'b000000, 1'b0, 3'b000, 4'b0000, 4'b1000, 4'b0011, 1'b0, 1'b1, 2'b01, 1'b0);
        s_exp[3] = mk(6'b010000, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b01, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0; out_ready = 1'b0;
        flush = 1'b0; instruction = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bundle", 32'(bundle_a), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'h1);

        // Plain ADD: one-cycle latency
        out_ready = 1'b1;
        instruction = c_add; in_valid = 1'b1; push("add", e_add, all_m);
        step();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'h1);
        step();
        check("add_drained", 32'(out_valid), 32'h0);

        // Asynchronous reset while a DIV is occupying the stage
        instruction = c_div; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("div_busy_pre_reset", 32'(out_valid), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_bundle", 32'(bundle_a), 32'h0);
        check("async_reset_valid", 32'(out_valid), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("ready_after_midreset", 32'(in_ready), 32'h1);

        // Back-pressure on a store, then pass-through refill
        out_ready = 1'b0;
        instruction = c_sw; in_valid = 1'b1; push("sw", e_sw, all_m);
        step();
        check("sw_valid", 32'(out_valid), 32'h1);
        instruction = c_sltiu;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'h0);
        repeat (2) begin
            step();
            check("bp_stable", 32'(bundle_a), 32'(e_sw));
            check("bp_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        check("refill_ready", 32'(in_ready), 32'h1);
        push("sltiu", e_sltiu, all_m);
        step();
        in_valid = 1'b0;
        check("sltiu_valid", 32'(out_valid), 32'h1);
        step();
        check("sltiu_drained", 32'(out_valid), 32'h0);

        // DIV latency 4: valid only after edge N+3
        instruction = c_div; in_valid = 1'b1; push("div", e_div, all_m);
        step();
        in_valid = 1'b0;
        check("div_busy_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("div_wait_valid", 32'(out_valid), 32'h0);
            step();
        end
        check("div_done_valid", 32'(out_valid), 32'h1);
        step();

        // FLUSH one cycle after a DIV accept; arriving ADDI must be dropped
        instruction = c_div; in_valid = 1'b1;
        step();
        instruction = c_addi; flush = 1'b1;
        step();
        check("flush_empty_ready", 32'(in_ready), 32'h1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flush_no_valid", 32'(out_valid), 32'h0);
            step();
        end
        check("flush_bundle_kept", 32'(alu_signal), 32'h0C);

        // Unsupported opcode
        instruction = c_bad; in_valid = 1'b1; push("illegal_opc", e_ill, m_ill);
        step();
        in_valid = 1'b0;
        check("illegal_valid", 32'(out_valid), 32'h1);
        check("illegal_flag", 32'(illegal), 32'h1);
        step();

        // MUL: legal single-cycle on the main instance, illegal on the M-less one
        instruction = c_mul; in_valid = 1'b1; in_valid_b = 1'b1; push("mul", e_mul, all_m);
        step();
        in_valid = 1'b0; in_valid_b = 1'b0;
        check("nom_mul_valid", 32'(b_out_valid), 32'h1);
        check("nom_mul_illegal", 32'(b_illegal), 32'h1);
        check("nom_mul_rfw", 32'(b_reg_file_write), 32'h0);
        step();
        check("nom_drained", 32'(b_out_valid), 32'h0);

        // Back-to-back stream at full throughput
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instruction = s_instr[i];
            push(s_tag[i], s_exp[i], all_m);
            step();
            check("stream_valid", 32'(out_valid), 32'h1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(out_valid), 32'h0);
        check("scoreboard_empty", 32'(sb_exp.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, handshaked successor to the combinational RV32IM control decoder. It sits between the fetch and execute stages. It decodes one instruction per transfer into the CPU control bundle and holds that bundle in an output register with valid/ready flow control. It inserts parametrised multi-cycle occupancy for M-extension MUL/DIV ops, flags illegal opcodes and supports a synchronous pipeline flush.

## Interface
- MUL_LATENCY, default 1: cycles a MUL/MULH* op occupies the stage before out_valid (≥1).
- DIV_LATENCY, default 4: cycles a DIV/DIVU/REM/REMU op occupies the stage before out_valid (≥1).
- ENABLE_M, default 1: 0 makes every OP opcode with funct7=0000001 illegal.
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  32  instruction word, sampled on accept.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- FLUSH  in  1  synchronous kill of held and arriving instruction.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  execute consumes the bundle.
- alu_signal  out  6  ALU op.
- reg_file_write  out  1  write enable for the register file.
- main_mem_write  out  3  [2] store, [1:0] funct3[1:0].
- main_mem_read  out  4  [3] load, [2:0] funct3.
- branch_control  out  4  [3] jump/branch, [2:0] condition.
- immediate_select  out  4  [3] unsigned, [2:0] format.
- operand_1_select, operand_2_select  out  1 each  PC / immediate select.
- reg_write_select  out  2  writeback source.
- illegal  out  1  held instruction is unsupported.

## Operation
- Decode (combinational, captured on accept). Opcode names: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011.
  - alu_signal[2:0]: 000 for AUIPC, JAL, LOAD, STORE and BRANCH; funct3 otherwise.
  - alu_signal[3]: OP with funct7=0000001, or LUI.
  - alu_signal[4]: SUB, SRA, SRAI or LUI.
  - alu_signal[5]: always 0.
  - reg_file_write: 0 for STORE, BRANCH and illegal.
  - branch_control[3]: JAL, JALR or BRANCH. branch_control[2:0]: 010 for JAL/JALR, else funct3.
  - immediate_select[2:0]:
    - LOAD/JALR/OPIMM → 010.
    - OPIMM shifts (funct3 x01) → 101.
    - AUIPC/LUI → 000.
    - JAL → 001.
    - BRANCH → 011.
    - STORE → 100.
  - immediate_select[3]: LBU, LHU, SLTIU, SLTU, MULHSU, MULHU or REMU.
  - operand_1_select: AUIPC, JAL or JALR.
  - operand_2_select: every opcode except OP.
  - reg_write_select[0]: not LOAD. reg_write_select[1]: AUIPC, JAL or JALR.
- Illegal = opcode outside the set above, or M op with ENABLE_M=0. An illegal op:
  - sets illegal=1;
  - forces reg_file_write=0, main_mem_write[2]=0, main_mem_read[3]=0 and branch_control[3]=0.
- State machine:
  - EMPTY: in_ready=1. On accept, a non-M op goes to FULL. An M op loads the counter with latency−1 (funct3[2]=1 selects DIV_LATENCY, else MUL_LATENCY) and goes to BUSY, or directly to FULL if latency=1.
  - BUSY: out_valid=0 and in_ready=0. The counter decrements each cycle. At counter==1 → FULL next edge.
  - FULL: out_valid=1. in_ready=out_ready (pass-through refill). A consume with no accept → EMPTY. A consume with an accept → reload per the EMPTY rules.
- FLUSH: highest priority. Next edge → EMPTY, counter=0, and the arriving instruction is dropped even if in_valid=1. in_ready is still driven normally during FLUSH.
- Counter width is $clog2(max(MUL_LATENCY,DIV_LATENCY)+1).

## Timing
- RESET low: state EMPTY, counter 0, out_valid=0. Every bundle output resets to 0, including reg_file_write, reg_write_select=00 and illegal=0. This applies immediately (asynchronous), including mid-BUSY.
- Latency: a non-M op accepted at edge N has out_valid=1 after edge N. An M op has out_valid=1 after edge N+L−1, where L is its latency.
- Bundle outputs change only on accept. They stay stable while out_valid=1 and out_ready=0.
- Throughput: 1 instruction/cycle for non-M streams when out_ready is held high.

## Test plan
- Reset: RESET=0 mid-stream → all outputs 0, in_ready=1 after release. Then ADD 0x00208033 accepted → next cycle out_valid=1, alu_signal=000000, reg_file_write=1, operand_2_select=0.
- Back-pressure: out_ready=0 with SW 0x0020A023 held → outputs stable (main_mem_write=110, reg_file_write=0, immediate_select=0100), in_ready=0. Release out_ready → bundle consumed, next op accepted in the same cycle.
- DIV latency with DIV_LATENCY=4: DIV 0x0220C033 accepted at edge N → out_valid=0 at N+1 and N+2, =1 after N+3, alu_signal=001100.
- FLUSH in BUSY: assert FLUSH one cycle after accepting DIV → EMPTY next edge, out_valid never rises, and the in_valid instruction presented during FLUSH is not captured.
- Illegal and ENABLE_M=0: opcode 0x0000007F → illegal=1, reg_file_write=0. MUL 0x02208033 with ENABLE_M=0 → illegal=1, no BUSY, out_valid next cycle.
- Back-to-back LUI, JAL, BEQ stream with out_ready=1 → one out_valid per cycle with:
  - LUI: alu_signal=011000, immediate_select=0000.
  - JAL: branch_control=1010, reg_write_select=11.
  - BEQ: branch_control=1000, immediate_select=0011.
